// File: rtl/multi_timer_pulse_pkg.sv
// ============================================================================
// multi_timer_pulse_pkg : shared channel state encoding and width helpers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_timer_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } ch_state_t;

    // Clock cycles per time-base tick.
    function automatic int tick_count(input longint clk_frequency, input int tick_us);
        return int'((clk_frequency / 64'd1_000_000) * longint'(tick_us));
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_timer_pulse_channel.sv
// ============================================================================
// multi_timer_pulse_channel : one periodic/one-shot pulse channel
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_timer_pulse_channel
    import multi_timer_pulse_pkg::*;
#(
    parameter int RATE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 en,
    input  logic                 oneshot,
    input  logic                 restart,
    input  logic [RATE_BITS-1:0] rate,
    output logic                 pulse,
    output logic                 busy
);

    ch_state_t            state;
    logic [RATE_BITS-1:0] ch_cnt;
    logic [RATE_BITS:0]   cnt_inc;
    logic                 rate_nz;
    logic                 fire;

    // One extra bit so ch_cnt+1 never wraps; a rate lowered under ch_cnt fires at once.
    assign cnt_inc = {1'b0, ch_cnt} + {{RATE_BITS{1'b0}}, 1'b1};
    assign rate_nz = |rate;
    assign fire    = (cnt_inc >= {1'b0, rate});

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_cnt <= '0;
            pulse  <= 1'b0;
            if (en && rate_nz) begin
                state <= ST_ARMED;
                busy  <= 1'b1;
            end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end
        end else begin
            pulse <= 1'b0;
            if (!en || !rate_nz) begin
                state  <= ST_IDLE;
                ch_cnt <= '0;
                busy   <= 1'b0;
            end else if (restart) begin
                // Restart wins over a coincident tick: that tick yields no pulse.
                state  <= ST_ARMED;
                ch_cnt <= '0;
                busy   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_ARMED;
                        ch_cnt <= '0;
                        busy   <= 1'b1;
                    end
                    ST_ARMED: begin
                        if (tick) begin
                            if (fire) begin
                                ch_cnt <= '0;
                                pulse  <= 1'b1;
                                if (oneshot) begin
                                    state <= ST_DONE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                ch_cnt <= cnt_inc[RATE_BITS-1:0];
                            end
                        end
                    end
                    ST_DONE: begin
                        busy <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        ch_cnt <= '0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_timer_pulse.sv
// ============================================================================
// multi_timer_pulse : NUM_CH pulse channels sharing one prescaled time base
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_timer_pulse
    import multi_timer_pulse_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int TICK_US       = 1000,
    parameter int NUM_CH        = 4,
    parameter int RATE_BITS     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             en,
    input  logic [NUM_CH-1:0]             oneshot,
    input  logic [NUM_CH-1:0]             restart,
    input  logic [NUM_CH*RATE_BITS-1:0]   rate,
    output logic [NUM_CH-1:0]             pulse,
    output logic [NUM_CH-1:0]             busy,
    output logic                          tick
);

    localparam int TICK_COUNT = tick_count(longint'(CLK_FREQUENCY), TICK_US);
    localparam int PRE_BITS   = cnt_width(TICK_COUNT);
    localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(TICK_COUNT - 1);

    logic [PRE_BITS-1:0] pre_cnt;

    // Free-running prescaler; deliberately independent of the channel enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= (pre_cnt == PRE_LAST);
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        multi_timer_pulse_channel #(
            .RATE_BITS (RATE_BITS)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .en      (en[ch]),
            .oneshot (oneshot[ch]),
            .restart (restart[ch]),
            .rate    (rate[ch*RATE_BITS +: RATE_BITS]),
            .pulse   (pulse[ch]),
            .busy    (busy[ch])
        );
    end

endmodule

`default_nettype wire
